// File: rtl/uart_tx.sv
// Double-buffered UART transmitter: one holding register feeding an 8N1/8N2
// shifter, with registered serial output, status flags and end-of-frame pulse.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 1000,
    parameter int unsigned INVERT       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [7:0] din,
    output logic       full,
    output logic       busy,
    output logic       done,
    output logic       tx
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned DATA_W = 8;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic             INV       = (INVERT != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                full_q, full_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                tx_q, tx_d;
    logic                line_d;
    logic                bit_end;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            hold_q  <= '0;
            full_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tx_q    <= ~INV;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            full_q  <= full_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic; outputs are derived from the next state so they line up with it
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        hold_d  = hold_q;
        full_d  = full_q;
        done_d  = 1'b0;
        line_d  = 1'b1;
        bit_end = (cnt_q == CNT_LAST);

        // Accept and unload are exclusive: one needs full_q=0, the other full_q=1
        if (we && !full_q) begin
            hold_d = din;
            full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (full_q) begin
                    shift_d = hold_q;
                    full_d  = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                // idx counts stop bits here so the counter never exceeds one bit period
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == STOP_LAST) begin
                        idx_d  = '0;
                        done_d = 1'b1;
                        if (full_q) begin
                            shift_d = hold_q;
                            full_d  = 1'b0;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase

        case (state_d)
            START:   line_d = 1'b0;
            DATA:    line_d = shift_d[idx_d];
            default: line_d = 1'b1;
        endcase

        tx_d   = line_d ^ INV;
        busy_d = (state_d != IDLE);
    end

    assign full = full_q;
    assign busy = busy_q;
    assign done = done_q;
    assign tx   = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: three instances cover the default
// framing, an inverted line and two stop bits, all at 4 clocks per bit.
module tb_uart_tx;

    localparam int unsigned CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       we0, we1, we2;
    logic [7:0] din;
    logic       full0, busy0, done0, tx0;
    logic       full1, busy1, done1, tx1;
    logic       full2, busy2, done2, tx2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(CPB), .INVERT(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .we(we0), .din(din),
        .full(full0), .busy(busy0), .done(done0), .tx(tx0)
    );
    uart_tx #(.CLKS_PER_BIT(CPB), .INVERT(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .we(we1), .din(din),
        .full(full1), .busy(busy1), .done(done1), .tx(tx1)
    );
    uart_tx #(.CLKS_PER_BIT(CPB), .INVERT(0), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .we(we2), .din(din),
        .full(full2), .busy(busy2), .done(done2), .tx(tx2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    function automatic logic get_tx(input int sel);
        case (sel)
            0:       return tx0;
            1:       return tx1;
            default: return tx2;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic get_done(input int sel);
        case (sel)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic get_full(input int sel);
        case (sel)
            0:       return full0;
            1:       return full1;
            default: return full2;
        endcase
    endfunction

    task automatic set_we(input int sel, input logic v);
        case (sel)
            0:       we0 = v;
            1:       we1 = v;
            default: we2 = v;
        endcase
    endtask

    // Walks ncyc cycles of a frame starting at its first start-bit cycle,
    // optionally offering writes at cycle indices wa / wb.
    task automatic frame(input int sel, input logic [7:0] data, input int nstop,
                         input logic inv, input int wa, input logic [7:0] wda,
                         input int wb, input logic [7:0] wdb, input int ncyc);
        logic line;
        logic exp_full;
        int   b;
        for (int i = 0; i < ncyc; i++) begin
            b = i / CPB;
            if (b == 0)      line = 1'b0;
            else if (b <= 8) line = data[b-1];
            else             line = 1'b1;
            check($sformatf("d%0d_%02h_tx_i%0d", sel, data, i), get_tx(sel), line ^ inv);
            check($sformatf("d%0d_%02h_busy_i%0d", sel, data, i), get_busy(sel), 1'b1);
            if (i > 0)
                check($sformatf("d%0d_%02h_done_i%0d", sel, data, i), get_done(sel), 1'b0);
            exp_full = (wa >= 0) && (i > wa);
            check($sformatf("d%0d_%02h_full_i%0d", sel, data, i), get_full(sel), exp_full);
            if (i == wa) begin
                din = wda;
                set_we(sel, 1'b1);
            end else if (i == wb) begin
                din = wdb;
                set_we(sel, 1'b1);
            end else begin
                set_we(sel, 1'b0);
            end
            step();
        end
        set_we(sel, 1'b0);
        if (nstop == 0) b = 0;
    endtask

    initial begin
        rst = 1'b1;
        we0 = 1'b0;
        we1 = 1'b0;
        we2 = 1'b0;
        din = 8'h00;
        step();
        step();
        check("rst_tx0", tx0, 1'b1);
        check("rst_tx1", tx1, 1'b0);
        check("rst_tx2", tx2, 1'b1);
        check("rst_full0", full0, 1'b0);
        check("rst_busy0", busy0, 1'b0);
        check("rst_done0", done0, 1'b0);
        rst = 1'b0;
        step();

        // Single frame 0x55
        din = 8'h55;
        we0 = 1'b1;
        step();
        we0 = 1'b0;
        check("w55_full_t1", full0, 1'b1);
        check("w55_tx_t1", tx0, 1'b1);
        check("w55_busy_t1", busy0, 1'b0);
        step();
        frame(0, 8'h55, 1, 1'b0, -1, 8'h00, -1, 8'h00, 40);
        check("w55_done", done0, 1'b1);
        check("w55_busy_after", busy0, 1'b0);
        check("w55_tx_after", tx0, 1'b1);
        step();
        check("w55_done_once", done0, 1'b0);
        step();

        // Back-to-back 0xA5 then 0x3C; 0xFF offered while full is dropped
        din = 8'hA5;
        we0 = 1'b1;
        step();
        we0 = 1'b0;
        step();
        frame(0, 8'hA5, 1, 1'b0, 12, 8'h3C, 20, 8'hFF, 40);
        check("a5_done", done0, 1'b1);
        check("a5_busy_next", busy0, 1'b1);
        check("a5_full_next", full0, 1'b0);
        frame(0, 8'h3C, 1, 1'b0, -1, 8'h00, -1, 8'h00, 40);
        check("3c_done", done0, 1'b1);
        check("3c_busy_after", busy0, 1'b0);
        step();
        check("3c_done_once", done0, 1'b0);
        step();

        // Reset during data bit 3 of 0x0F with 0xF0 held; write during reset ignored
        din = 8'h0F;
        we0 = 1'b1;
        step();
        we0 = 1'b0;
        step();
        frame(0, 8'h0F, 1, 1'b0, 4, 8'hF0, -1, 8'h00, 17);
        rst = 1'b1;
        we0 = 1'b1;
        din = 8'hAA;
        step();
        check("rst_mid_tx", tx0, 1'b1);
        check("rst_mid_full", full0, 1'b0);
        check("rst_mid_busy", busy0, 1'b0);
        check("rst_mid_done", done0, 1'b0);
        rst = 1'b0;
        we0 = 1'b0;
        step();
        check("rst_we_ignored", full0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            check($sformatf("post_rst_tx_%0d", i), tx0, 1'b1);
            check($sformatf("post_rst_busy_%0d", i), busy0, 1'b0);
            check($sformatf("post_rst_done_%0d", i), done0, 1'b0);
            step();
        end

        // Inverted line, 0x00
        check("inv_idle", tx1, 1'b0);
        din = 8'h00;
        we1 = 1'b1;
        step();
        we1 = 1'b0;
        check("inv_tx_t1", tx1, 1'b0);
        step();
        frame(1, 8'h00, 1, 1'b1, -1, 8'h00, -1, 8'h00, 40);
        check("inv_done", done1, 1'b1);
        check("inv_tx_after", tx1, 1'b0);
        check("inv_busy_after", busy1, 1'b0);
        step();
        check("inv_done_once", done1, 1'b0);

        // Two stop bits, 0x81
        din = 8'h81;
        we2 = 1'b1;
        step();
        we2 = 1'b0;
        step();
        frame(2, 8'h81, 2, 1'b0, -1, 8'h00, -1, 8'h00, 44);
        check("sb2_done", done2, 1'b1);
        check("sb2_busy_after", busy2, 1'b0);
        check("sb2_tx_after", tx2, 1'b1);
        step();
        check("sb2_done_once", done2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1000, clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter INVERT, default 0, when 1 the tx output is the logical inverse of the serial line level.
REQ-003 Parameter STOP_BITS, default 1, number of stop bits per frame; legal values 1 or 2.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 we  input  1  write enable; offers din to the holding register.
REQ-007 din  input  8  byte to transmit; sampled only on an accepted write.
REQ-008 full  output  1  holding register occupied; registered.
REQ-009 busy  output  1  shifter transmitting a frame (START, DATA or STOP); registered.
REQ-010 done  output  1  one-cycle pulse at the end of each frame's final stop-bit cycle; registered.
REQ-011 tx  output  1  serial output, registered, after INVERT.

Function
REQ-012 Frame shall be: 1 start bit (line 0), 8 data bits LSB first, STOP_BITS stop bits (line 1); idle line level 1.
REQ-013 Write accepted when we=1 and registered full=0; din latched, full=1 from the next cycle.
REQ-014 we while full=1 shall be ignored: holding byte, full, and frame unaffected; no error flag.
REQ-015 States: IDLE, START, DATA, STOP; 2-bit state, 16-bit bit-period counter, 3-bit bit index.
REQ-016 IDLE: tx at idle level; busy=0; if full=1, move holding byte to shifter, full=0 and state=START next cycle.
REQ-017 Write accepted in cycle t from idle: full=1 at t+1, start bit on tx at t+2.
REQ-018 START: line 0 for exactly CLKS_PER_BIT cycles, then DATA with index=0.
REQ-019 DATA: each bit driven for exactly CLKS_PER_BIT cycles; index increments at each bit end; after index 7 go to STOP.
REQ-020 STOP: line 1 for exactly STOP_BITS*CLKS_PER_BIT cycles.
REQ-021 In the final STOP cycle: done=1 next cycle for one cycle only; if full=1, load holding byte, full=0 and go directly to START (no idle bit between frames), else go to IDLE.
REQ-022 Total frame length: (9+STOP_BITS)*CLKS_PER_BIT cycles; back-to-back frames contiguous.
REQ-023 A write is accepted while busy=1 if full=0 (double buffering); a write in the same cycle the holding register is emptied is ignored because full is the registered value.
REQ-024 Shifter contents shall never be altered by we or din during a frame.
REQ-025 done shall be 0 in every cycle other than the one following a frame's final stop cycle.
REQ-026 Illegal state encodings shall return to IDLE on the next cycle.

Reset
REQ-027 rst=1 at a rising edge: state=IDLE, full=0, busy=0, done=0, counter=0, index=0, tx=idle level (1 if INVERT=0, 0 if INVERT=1).
REQ-028 Reset mid-frame shall abort the frame and discard any held byte; tx returns to idle level on the cycle after the reset edge.
REQ-029 we during rst=1 shall be ignored.

Verification (CLKS_PER_BIT=4, INVERT=0, STOP_BITS=1 unless stated)
REQ-030 Write 0x55 from idle -> from t+2, tx = 0,1,0,1,0,1,0,1,0,1 with 4 cycles per bit (40 cycles); done pulses once, 1 cycle; busy=0 afterwards.
REQ-031 Write 0xA5, then 0x3C during the first frame's data bits -> second write accepted (full=1), frames contiguous with no idle gap, LSB-first bits 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0; two done pulses 40 cycles apart.
REQ-032 With full=1 and a frame in progress, write 0xFF -> ignored; held byte transmitted unchanged afterwards.
REQ-033 Assert rst during data bit 3 of 0x0F with 0xF0 held -> next cycle tx=1, full=0, busy=0, done=0; no further frames sent.
REQ-034 INVERT=1, write 0x00 -> idle tx=0; start bit tx=1; data bits tx=1; stop bit tx=0.
REQ-035 STOP_BITS=2, write 0x81 -> stop phase 8 cycles at line 1; frame 44 cycles; done once at the end.
